// File: rtl/stdio_fifo.sv
// Elastic val/rdy word buffer for the console stdio path.
// A circular buffer with a separately tracked occupancy. It also keeps a sticky
// high-water mark that clears on reset or flush.
module stdio_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         clr_i,
  input  logic                         in_val_i,
  input  logic [WIDTH-1:0]             in_data_i,
  output logic                         in_rdy_o,
  output logic                         out_val_o,
  output logic [WIDTH-1:0]             out_data_o,
  input  logic                         out_rdy_i,
  output logic [$clog2(DEPTH+1)-1:0]   level_o,
  output logic [$clog2(DEPTH+1)-1:0]   hwm_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [LVL_W-1:0] level;
  logic [LVL_W-1:0] level_next;
  logic [LVL_W-1:0] hwm;
  logic             push;
  logic             pop;

  // Handshake flags come from registered occupancy only.
  assign in_rdy_o  = (level != LVL_W'(DEPTH));
  assign out_val_o = (level != '0);
  assign push      = in_val_i && in_rdy_o;
  assign pop       = out_val_o && out_rdy_i;
  assign level_o   = level;
  assign hwm_o     = hwm;

  // The head word is forced to zero while empty, so stale storage never shows.
  assign out_data_o = out_val_o ? mem[rd_ptr] : '0;

  // Next occupancy: +1 on push only, -1 on pop only, otherwise unchanged.
  always_comb begin
    level_next = level;
    if (push && !pop) begin
      level_next = level + LVL_W'(1);
    end else if (pop && !push) begin
      level_next = level - LVL_W'(1);
    end
  end

  // Pointer, occupancy and high-water state. Flush overrides any push or pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      hwm    <= '0;
    end else if (clr_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      level  <= '0;
      hwm    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      level <= level_next;
      if (level_next > hwm) begin
        hwm <= level_next;
      end
    end
  end

  // Storage write. The array is not reset; a flushed push never lands.
  always_ff @(posedge clk_i) begin
    if (push && !clr_i) begin
      mem[wr_ptr] <= in_data_i;
    end
  end

  // A stalled producer must hold its word until it is accepted.
  property p_producer_hold;
    @(posedge clk_i) disable iff (!rst_ni || clr_i)
      (in_val_i && !in_rdy_o) |=> (in_val_i && $stable(in_data_i));
  endproperty
  a_producer_hold: assert property (p_producer_hold)
    else $error("stdio_fifo: producer dropped or changed a stalled word");

endmodule
